// File: rtl/pc_pkg.sv
// Shared op encodings for the program-counter sequencer.
package pc_pkg;

    localparam int unsigned PC_OP_W = 3;

    localparam logic [PC_OP_W-1:0] PC_OP_INC    = 3'b000;
    localparam logic [PC_OP_W-1:0] PC_OP_BRANCH = 3'b001;
    localparam logic [PC_OP_W-1:0] PC_OP_JUMP   = 3'b010;
    localparam logic [PC_OP_W-1:0] PC_OP_CALL   = 3'b011;
    localparam logic [PC_OP_W-1:0] PC_OP_RET    = 3'b100;

endpackage

// File: rtl/ras_stack.sv
// Return-address LIFO: registered depth/full/empty, combinational top-of-stack read.
module ras_stack #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                               CLK,
    input  logic                               areset,
    input  logic                               push,
    input  logic                               pop,
    input  logic [ADDR_W-1:0]                  din,
    output logic [ADDR_W-1:0]                  dout,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               full,
    output logic                               empty
);

    localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);

    logic [ADDR_W-1:0] r_mem [STACK_DEPTH];
    logic [CNT_W-1:0]  r_depth;
    logic              r_full;
    logic              r_empty;
    logic [CNT_W-1:0]  w_depth_nxt;
    logic              w_push;
    logic              w_pop;

    // Self-protect against push-when-full and pop-when-empty.
    assign w_push = push && !r_full;
    assign w_pop  = pop && !r_empty;

    always_comb begin
        w_depth_nxt = r_depth;
        if (w_push) begin
            w_depth_nxt = r_depth + CNT_W'(1);
        end else if (w_pop) begin
            w_depth_nxt = r_depth - CNT_W'(1);
        end
    end

    always_ff @(negedge CLK) begin
        if (areset) begin
            r_depth <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_depth <= w_depth_nxt;
            r_full  <= (w_depth_nxt == CNT_W'(STACK_DEPTH));
            r_empty <= (w_depth_nxt == '0);
        end
    end

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(negedge CLK) begin
        if (!areset && w_push) begin
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                if (CNT_W'(i) == r_depth) begin
                    r_mem[i] <= din;
                end
            end
        end
    end

    always_comb begin
        dout = '0;
        for (int i = 0; i < int'(STACK_DEPTH); i++) begin
            if (CNT_W'(i + 1) == r_depth) begin
                dout = r_mem[i];
            end
        end
    end

    assign depth = r_depth;
    assign full  = r_full;
    assign empty = r_empty;

endmodule

// File: rtl/pc_seq_unit.sv
// Fetch-stage program counter: increment, relative branch, jump, call/return with sticky stack errors.
module pc_seq_unit
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input  logic                               CLK,
    input  logic                               areset,
    input  logic                               stall,
    input  logic [PC_OP_W-1:0]                 op,
    input  logic                               cond,
    input  logic [ADDR_W-1:0]                  offset,
    input  logic [ADDR_W-1:0]                  target,
    output logic [ADDR_W-1:0]                  addr_out,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               full,
    output logic                               empty,
    output logic                               ovf_err,
    output logic                               unf_err
);

    logic [ADDR_W-1:0] r_pc;
    logic              r_ovf;
    logic              r_unf;

    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_top;
    logic              w_push;
    logic              w_pop;
    logic              w_ovf_set;
    logic              w_unf_set;
    logic              w_full;
    logic              w_empty;

    assign w_pc_inc = r_pc + ADDR_W'(1);

    // Next-PC mux; a signed offset added in ADDR_W bits wraps like sign extension.
    always_comb begin
        w_pc_nxt  = r_pc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        if (!stall) begin
            w_pc_nxt = w_pc_inc;
            case (op)
                PC_OP_BRANCH: begin
                    if (cond) begin
                        w_pc_nxt = r_pc + offset;
                    end
                end
                PC_OP_JUMP: begin
                    w_pc_nxt = target;
                end
                PC_OP_CALL: begin
                    if (!w_full) begin
                        w_push   = 1'b1;
                        w_pc_nxt = target;
                    end else begin
                        w_ovf_set = 1'b1;
                    end
                end
                PC_OP_RET: begin
                    if (!w_empty) begin
                        w_pop    = 1'b1;
                        w_pc_nxt = w_top;
                    end else begin
                        w_unf_set = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(negedge CLK) begin
        if (areset) begin
            r_pc  <= RESET_ADDR;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_pc  <= w_pc_nxt;
            r_ovf <= r_ovf | w_ovf_set;
            r_unf <= r_unf | w_unf_set;
        end
    end

    ras_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ras_stack (
        .CLK    (CLK),
        .areset (areset),
        .push   (w_push),
        .pop    (w_pop),
        .din    (w_pc_inc),
        .dout   (w_top),
        .depth  (depth),
        .full   (w_full),
        .empty  (w_empty)
    );

    assign addr_out = r_pc;
    assign full     = w_full;
    assign empty    = w_empty;
    assign ovf_err  = r_ovf;
    assign unf_err  = r_unf;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Scoreboard bench for pc_seq_unit: reference model queues expectations, compared after each falling edge.
module tb_pc_seq_unit;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned SD     = 4;

    logic             CLK = 1'b0;
    logic             areset = 1'b1;
    logic             stall = 1'b0;
    logic [2:0]       op = 3'b000;
    logic             cond = 1'b0;
    logic [7:0]       offset = 8'h00;
    logic [7:0]       target = 8'h00;
    logic [7:0]       addr_out;
    logic [2:0]       depth;
    logic             full;
    logic             empty;
    logic             ovf_err;
    logic             unf_err;

    typedef struct {
        logic [7:0] pc;
        int         dep;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_pc;
    logic [7:0] m_stk[$];
    logic       m_ovf;
    logic       m_unf;
    int         n_tests = 0;
    int         n_fail  = 0;

    pc_seq_unit #(.ADDR_W(ADDR_W), .STACK_DEPTH(SD), .RESET_ADDR(8'h00)) dut (
        .CLK      (CLK),
        .areset   (areset),
        .stall    (stall),
        .op       (op),
        .cond     (cond),
        .offset   (offset),
        .target   (target),
        .addr_out (addr_out),
        .depth    (depth),
        .full     (full),
        .empty    (empty),
        .ovf_err  (ovf_err),
        .unf_err  (unf_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one op, advance the model, then compare after the falling edge.
    task automatic step(input logic r, input logic s, input logic [2:0] o,
                        input logic c, input logic [7:0] off, input logic [7:0] tgt);
        exp_t e;
        @(posedge CLK);
        areset = r; stall = s; op = o; cond = c; offset = off; target = tgt;
        if (r) begin
            m_pc = 8'h00; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else if (!s) begin
            case (o)
                3'b001: m_pc = c ? m_pc + off : m_pc + 8'd1;
                3'b010: m_pc = tgt;
                3'b011: begin
                    if (m_stk.size() < SD) begin
                        m_stk.push_back(m_pc + 8'd1);
                        m_pc = tgt;
                    end else begin
                        m_pc = m_pc + 8'd1;
                        m_ovf = 1'b1;
                    end
                end
                3'b100: begin
                    if (m_stk.size() > 0) begin
                        m_pc = m_stk.pop_back();
                    end else begin
                        m_pc = m_pc + 8'd1;
                        m_unf = 1'b1;
                    end
                end
                default: m_pc = m_pc + 8'd1;
            endcase
        end
        e.pc = m_pc; e.dep = m_stk.size();
        e.full = (m_stk.size() == SD); e.empty = (m_stk.size() == 0);
        e.ovf = m_ovf; e.unf = m_unf;
        sb.push_back(e);
        @(negedge CLK);
        #1;
        e = sb.pop_front();
        chk("pc",    32'(addr_out), 32'(e.pc));
        chk("depth", 32'(depth),    32'(e.dep));
        chk("full",  32'(full),     32'(e.full));
        chk("empty", 32'(empty),    32'(e.empty));
        chk("ovf",   32'(ovf_err),  32'(e.ovf));
        chk("unf",   32'(unf_err),  32'(e.unf));
    endtask

    task automatic op_(input logic [2:0] o, input logic [7:0] tgt);
        step(1'b0, 1'b0, o, 1'b0, 8'h00, tgt);
    endtask

    task automatic rst_();
        step(1'b1, 1'b0, 3'b000, 1'b0, 8'h00, 8'h00);
    endtask

    logic [7:0] pc_hold;

    initial begin
        m_pc = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;

        // Reset and increment.
        rst_();
        chk("rst_pc", 32'(addr_out), 32'h00);
        chk("rst_empty", 32'(empty), 32'h1);
        op_(3'b000, 8'h00); op_(3'b000, 8'h00); op_(3'b000, 8'h00);
        chk("inc3", 32'(addr_out), 32'h03);

        // Wrap and branch.
        op_(3'b010, 8'hFF); op_(3'b000, 8'h00);
        chk("wrap", 32'(addr_out), 32'h00);
        op_(3'b010, 8'h05); step(1'b0, 1'b0, 3'b001, 1'b1, 8'hFE, 8'h00);
        chk("br_neg", 32'(addr_out), 32'h03);
        op_(3'b010, 8'h05); step(1'b0, 1'b0, 3'b001, 1'b1, 8'h7F, 8'h00);
        chk("br_pos", 32'(addr_out), 32'h84);
        op_(3'b010, 8'h05); step(1'b0, 1'b0, 3'b001, 1'b0, 8'h7F, 8'h00);
        chk("br_nt", 32'(addr_out), 32'h06);

        // Nested call/return, back-to-back.
        op_(3'b010, 8'h10); op_(3'b011, 8'h40); op_(3'b011, 8'h80);
        chk("call2_depth", 32'(depth), 32'h2);
        op_(3'b100, 8'h00);
        chk("ret1", 32'(addr_out), 32'h41);
        op_(3'b100, 8'h00);
        chk("ret2", 32'(addr_out), 32'h11);

        // CALL at the top address pushes the wrapped zero.
        op_(3'b010, 8'hFF); op_(3'b011, 8'h10); op_(3'b100, 8'h00);
        chk("call_wrap", 32'(addr_out), 32'h00);

        // Overflow: fill, fifth call, unwind.
        op_(3'b010, 8'h30);
        op_(3'b011, 8'h50); op_(3'b011, 8'h60); op_(3'b011, 8'h70); op_(3'b011, 8'h80);
        chk("full4", 32'(full), 32'h1);
        op_(3'b011, 8'h90);
        chk("ovf_pc", 32'(addr_out), 32'h81);
        chk("ovf_flag", 32'(ovf_err), 32'h1);
        op_(3'b100, 8'h00); chk("ovf_ret1", 32'(addr_out), 32'h71);
        op_(3'b100, 8'h00); op_(3'b100, 8'h00); op_(3'b100, 8'h00);
        chk("ovf_ret4", 32'(addr_out), 32'h31);
        chk("ovf_sticky", 32'(ovf_err), 32'h1);

        // Underflow.
        rst_(); op_(3'b010, 8'h20); op_(3'b100, 8'h00);
        chk("unf_pc", 32'(addr_out), 32'h21);
        op_(3'b000, 8'h00);
        chk("unf_sticky", 32'(unf_err), 32'h1);

        // Stall, reset during stall at depth 3, reserved op.
        pc_hold = addr_out;
        step(1'b0, 1'b1, 3'b011, 1'b0, 8'h00, 8'h40);
        chk("stall_pc", 32'(addr_out), 32'(pc_hold));
        op_(3'b011, 8'h40); op_(3'b011, 8'h50); op_(3'b011, 8'h60);
        step(1'b1, 1'b1, 3'b011, 1'b0, 8'h00, 8'h70);
        chk("rst_stall_depth", 32'(depth), 32'h0);
        chk("rst_stall_unf", 32'(unf_err), 32'h0);
        op_(3'b110, 8'h00);
        chk("rsvd", 32'(addr_out), 32'h01);

        // Random mix with occasional stall and reset.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 8'($urandom), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
